// File: rtl/chebyshev_pkg.sv
// chebyshev_pkg: state encoding and coefficient-address helpers shared by the Chebyshev sequencer.
package chebyshev_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Segment index occupies the MSBs of the ROM address, degree index the LSBs.
    localparam bit ADDR_SEG_IN_MSB = 1'b1;

    function automatic int seg_bits_f(input int s);
        return (s < 2) ? 1 : $clog2(s);
    endfunction

    function automatic int k_bits_f(input int degree);
        return (degree < 1) ? 1 : $clog2(degree + 1);
    endfunction

    function automatic int coeff_addr_f(input int seg, input int k, input int sb, input int kb);
        return ADDR_SEG_IN_MSB ? ((seg << kb) | k) : ((k << sb) | seg);
    endfunction

endpackage

// File: rtl/chebyshev_step_timer.sv
// chebyshev_step_timer: loadable down-counter pacing each recurrence step; flags zero.
module chebyshev_step_timer #(
    parameter int W = 2
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = load_i ? load_val_i : ((cnt_q != '0) ? cnt_q - W'(1) : cnt_q);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/chebyshev_sequencer.sv
// chebyshev_sequencer: sequences one Clenshaw evaluation per sample over the shared datapath.
// Optional CHEB_SEQ_PERF_CNT_EN adds saturating busy_cycles / samples_done counters.
module chebyshev_sequencer
    import chebyshev_pkg::*;
#(
    parameter int WL       = 16,
    parameter int I_BITS   = 2,
    parameter int S        = 8,
    parameter int DEGREE   = 4,
    parameter int COMP_LAT = 2,
    parameter int O_BITS   = 16,
    localparam int SEG_BITS = seg_bits_f(S),
    localparam int K_BITS   = k_bits_f(DEGREE),
    localparam int AW       = SEG_BITS + K_BITS,
    localparam int XW       = WL - I_BITS
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WL-1:0]     data_in,
    output logic [AW-1:0]     coeff_addr,
    output logic              coeff_rd_en,
    output logic [XW-1:0]     comp_x,
    output logic              comp_clear,
    output logic              comp_step,
    output logic              comp_last,
    input  logic [O_BITS-1:0] comp_result,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef CHEB_SEQ_PERF_CNT_EN
    output logic [31:0]       busy_cycles,
    output logic [31:0]       samples_done,
`endif
    output logic [O_BITS-1:0] data_out
);

    localparam int T_BITS = $clog2(COMP_LAT + 1);

    logic [1:0]          state_q, state_d;
    logic [SEG_BITS-1:0] seg_q, seg_d;
    logic [K_BITS-1:0]   k_q, k_d;
    logic [XW-1:0]       x_q, x_d;
    logic [O_BITS-1:0]   res_q, res_d;
    logic                first_q;
    logic                tmr_zero, accept, handshake;
    logic [T_BITS-1:0]   tmr_load_val;

    assign handshake = (state_q == ST_DONE) && out_ready;
    assign in_ready  = (state_q == ST_IDLE) || handshake;
    assign accept    = in_valid && in_ready;

    // Final step waits one extra cycle so the rounding stage has settled before capture.
    assign tmr_load_val = (k_q == '0) ? T_BITS'(COMP_LAT) : T_BITS'(COMP_LAT - 1);

    chebyshev_step_timer #(.W(T_BITS)) u_timer (
        .clock      (clock),
        .resetn     (resetn),
        .load_i     (state_q == ST_ISSUE),
        .load_val_i (tmr_load_val),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d = state_q;
        seg_d   = seg_q;
        k_d     = k_q;
        x_d     = x_q;
        res_d   = res_q;
        if (accept) begin
            x_d     = data_in[XW-1:0];
            seg_d   = data_in[XW-1 -: SEG_BITS];
            k_d     = K_BITS'(DEGREE);
            state_d = ST_ISSUE;
        end else if (handshake) begin
            state_d = ST_IDLE;
        end else if (state_q == ST_ISSUE) begin
            state_d = ST_WAIT;
        end else if (state_q == ST_WAIT && tmr_zero) begin
            if (k_q != '0) begin
                k_d     = k_q - K_BITS'(1);
                state_d = ST_ISSUE;
            end else begin
                res_d   = comp_result;
                state_d = ST_DONE;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            seg_q   <= '0;
            k_q     <= K_BITS'(DEGREE);
            x_q     <= '0;
            res_q   <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            seg_q   <= seg_d;
            k_q     <= k_d;
            x_q     <= x_d;
            res_q   <= res_d;
            first_q <= (state_q == ST_ISSUE);
        end
    end

    assign coeff_rd_en = (state_q == ST_ISSUE);
    assign coeff_addr  = coeff_rd_en ? AW'(coeff_addr_f(int'(seg_q), int'(k_q), SEG_BITS, K_BITS)) : '0;
    assign comp_step   = (state_q == ST_WAIT) && first_q;
    assign comp_clear  = comp_step && (k_q == K_BITS'(DEGREE));
    assign comp_last   = comp_step && (k_q == '0);
    assign comp_x      = x_q;
    assign out_valid   = (state_q == ST_DONE);
    assign data_out    = res_q;

`ifdef CHEB_SEQ_PERF_CNT_EN
    logic [31:0] busy_q, done_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            busy_q <= '0;
            done_q <= '0;
        end else begin
            if (state_q != ST_IDLE && !(&busy_q)) busy_q <= busy_q + 32'd1;
            if (handshake && !(&done_q))          done_q <= done_q + 32'd1;
        end
    end

    assign busy_cycles  = busy_q;
    assign samples_done = done_q;
`endif

endmodule

// File: tb/tb_chebyshev_sequencer.sv
// tb_chebyshev_sequencer: randomized cycle-level check of the sequencer against a timeline model.
module tb_chebyshev_sequencer;

    localparam int WL = 16, I_BITS = 2, S = 8, DEGREE = 4, COMP_LAT = 2, O_BITS = 16;
    localparam int SB = 3, KB = 3, AW = SB + KB, XW = WL - I_BITS;
    localparam int P = COMP_LAT + 1;
    localparam int L = (DEGREE + 1) * P + 1;

    logic              clock, resetn, in_valid, in_ready, out_ready, out_valid;
    logic              coeff_rd_en, comp_clear, comp_step, comp_last;
    logic [WL-1:0]     data_in;
    logic [AW-1:0]     coeff_addr;
    logic [XW-1:0]     comp_x;
    logic [O_BITS-1:0] comp_result, data_out;
`ifdef CHEB_SEQ_PERF_CNT_EN
    logic [31:0]       busy_cycles, samples_done;
`endif

    chebyshev_sequencer dut (
        .clock       (clock),
        .resetn      (resetn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .data_in     (data_in),
        .coeff_addr  (coeff_addr),
        .coeff_rd_en (coeff_rd_en),
        .comp_x      (comp_x),
        .comp_clear  (comp_clear),
        .comp_step   (comp_step),
        .comp_last   (comp_last),
        .comp_result (comp_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
`ifdef CHEB_SEQ_PERF_CNT_EN
        .busy_cycles (busy_cycles),
        .samples_done(samples_done),
`endif
        .data_out    (data_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec = 0, n_err = 0;

    // Model: t counts cycles since the accepting edge; the whole schedule is derived from t.
    bit                act = 0;
    int                t = 0, m_seg = 0, m_busy = 0, m_samples = 0;
    logic [XW-1:0]     m_x = '0;
    logic [O_BITS-1:0] m_res = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    task automatic chk_reset_values();
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst coeff_rd_en", 32'(coeff_rd_en), 32'd0);
        chk("rst comp_step", 32'(comp_step), 32'd0);
        chk("rst comp_clear", 32'(comp_clear), 32'd0);
        chk("rst comp_last", 32'(comp_last), 32'd0);
        chk("rst coeff_addr", 32'(coeff_addr), 32'd0);
        chk("rst comp_x", 32'(comp_x), 32'd0);
        chk("rst data_out", 32'(data_out), 32'd0);
`ifdef CHEB_SEQ_PERF_CNT_EN
        chk("rst busy_cycles", busy_cycles, 32'd0);
        chk("rst samples_done", samples_done, 32'd0);
`endif
    endtask

    task automatic cycle(input logic iv, input logic [WL-1:0] din, input logic ordy);
        bit done, ev, rd, st, rdy;
        int k;
        @(negedge clock);
        in_valid = iv;
        data_in = din;
        out_ready = ordy;
        comp_result = O_BITS'($urandom);
        #1;
        done = act && t >= L;
        ev = act && t < L - 1;
        rd = ev && (t % P == 0);
        st = ev && (t % P == 1);
        k = DEGREE - t / P;
        rdy = !act || (done && ordy);
        chk("in_ready", 32'(in_ready), 32'(rdy));
        chk("out_valid", 32'(out_valid), 32'(done));
        chk("coeff_rd_en", 32'(coeff_rd_en), 32'(rd));
        chk("coeff_addr", 32'(coeff_addr), rd ? m_seg * (2 ** KB) + k : 0);
        chk("comp_step", 32'(comp_step), 32'(st));
        chk("comp_clear", 32'(comp_clear), 32'(st && k == DEGREE));
        chk("comp_last", 32'(comp_last), 32'(st && k == 0));
        chk("comp_x", 32'(comp_x), 32'(m_x));
        chk("data_out", 32'(data_out), 32'(m_res));
`ifdef CHEB_SEQ_PERF_CNT_EN
        chk("busy_cycles", busy_cycles, 32'(m_busy));
        chk("samples_done", samples_done, 32'(m_samples));
`endif
        if (act) m_busy++;
        if (act && !done) begin
            if (t == L - 1) m_res = comp_result;
            t++;
        end
        if (done && ordy) begin
            act = 0;
            m_samples++;
        end
        if (iv && rdy) begin
            act = 1;
            t = 0;
            m_x = din[XW-1:0];
            m_seg = int'(din[XW-1 -: SB]);
        end
    endtask

    task automatic async_reset();
        @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        act = 0;
        t = 0;
        m_x = '0;
        m_res = '0;
        m_busy = 0;
        m_samples = 0;
        chk_reset_values();
        @(posedge clock);
        #2 resetn = 1'b1;
    endtask

    initial begin
        resetn = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        data_in = '0;
        comp_result = '0;
        repeat (2) @(negedge clock);
        #1 chk_reset_values();
        resetn = 1'b1;
        // single sample, then stall out_ready with stray in_valid pulses
        cycle(1'b1, 16'h1A00, 1'b0);
        repeat (L + 10) cycle(1'($urandom_range(0, 1)), 16'($urandom), 1'b0);
        cycle(1'b0, 16'h0, 1'b1);
        // back-to-back accepts in each handshake cycle
        repeat (4 * (L + 1) + 1) cycle(1'b1, 16'($urandom), 1'b1);
        repeat (3) cycle(1'b0, 16'h0, 1'b1);
        // abort during the k=2 wait, then a full evaluation
        cycle(1'b1, 16'h2C55, 1'b1);
        repeat (2 * P + 2) cycle(1'b0, 16'h0, 1'b1);
        async_reset();
        cycle(1'b1, 16'h1234, 1'b1);
        repeat (L + 2) cycle(1'b0, 16'h0, 1'b1);
        // edge segments
        cycle(1'b1, 16'h0000, 1'b1);
        repeat (L + 2) cycle(1'b0, 16'h0, 1'b1);
        cycle(1'b1, 16'h3FFF, 1'b1);
        repeat (L + 2) cycle(1'b0, 16'h0, 1'b1);
        cycle(1'b1, 16'hFFFF, 1'b1);
        repeat (L + 2) cycle(1'b0, 16'h0, 1'b1);
        // random traffic
        repeat (600) cycle(1'($urandom_range(0, 2) != 0), 16'($urandom), 1'($urandom_range(0, 3) != 0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
